// File: rtl/token_pkg.sv
// Shared defaults and sizing helper for single-bit token-stream blocks.
package token_pkg;

    localparam int TOKEN_FACTOR_DEF      = 2;
    localparam int TOKEN_MAX_PENDING_DEF = 4;

    // Width of a counter that must hold 0 .. max_pending inclusive.
    function automatic int token_cnt_w(input int max_pending);
        return (max_pending < 1) ? 1 : $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/token_backlog_cnt.sv
// Bounded backlog counter: +FACTOR per accepted request, -1 per cycle while non-zero.
// Latency 1 cycle; ready is combinational from count only and guarantees count never exceeds MAX_PENDING.
module token_backlog_cnt
    import token_pkg::*;
#(
    parameter int  FACTOR      = TOKEN_FACTOR_DEF,
    parameter int  MAX_PENDING = TOKEN_MAX_PENDING_DEF,
    localparam int W           = token_cnt_w(MAX_PENDING)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up,
    output logic         ready,
    output logic [W-1:0] count
);

    localparam logic [W:0] LIM  = (W+1)'(MAX_PENDING - FACTOR + 1);
    localparam logic [W:0] INC  = (W+1)'(FACTOR);
    localparam logic [W:0] MAXV = (W+1)'(MAX_PENDING);

    logic [W:0] cnt_ext;
    logic [W:0] nxt;
    logic       dec;
    logic       accept;

    assign cnt_ext = {1'b0, count};
    assign ready   = (cnt_ext <= LIM);
    assign dec     = (count != '0);
    assign accept  = up && ready;

    // One extra bit so the decrement and increment of the same edge net out without wrap.
    assign nxt = cnt_ext - {{W{1'b0}}, dec} + (accept ? INC : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (nxt > MAXV) begin
            count <= MAXV[W-1:0];
        end else begin
            count <= nxt[W-1:0];
        end
    end

endmodule

// File: rtl/token_multiplier.sv
// Expands each accepted '1' on a into FACTOR back-to-back '1's on b; first output 2 cycles after input.
// Backpressure via a_ready when the backlog is near full; refused tokens set a sticky overflow and count drops.
module token_multiplier
    import token_pkg::*;
#(
    parameter int FACTOR      = TOKEN_FACTOR_DEF,
    parameter int MAX_PENDING = TOKEN_MAX_PENDING_DEF,
    parameter int DROP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    output logic              a_ready,
    input  logic              clr_ovf,
    output logic              b,
    output logic              busy,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int              PW       = token_cnt_w(MAX_PENDING);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    if (FACTOR < 1) begin : g_bad_factor
        $fatal(1, "token_multiplier: FACTOR must be >= 1");
    end
    if (MAX_PENDING < FACTOR) begin : g_bad_max_pending
        $fatal(1, "token_multiplier: MAX_PENDING must be >= FACTOR");
    end

    logic [PW-1:0] pending;
    logic          emit;
    logic          drop;

    token_backlog_cnt #(
        .FACTOR      (FACTOR),
        .MAX_PENDING (MAX_PENDING)
    ) u_backlog (
        .clk   (clk),
        .rst   (rst),
        .up    (a),
        .ready (a_ready),
        .count (pending)
    );

    assign emit = (pending != '0);
    assign drop = a && !a_ready;
    assign busy = emit || b;

    // A drop on the same edge as a clear wins: the flag stays set and the count restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            b        <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            b <= emit;
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf) begin
                    drop_cnt <= DROP_ONE;
                end else if (!(&drop_cnt)) begin
                    drop_cnt <= drop_cnt + DROP_ONE;
                end
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_token_multiplier.sv
module tb_token_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, clr_ovf;
    logic       a_ready, b, busy, overflow;
    logic [7:0] drop_cnt;

    logic       a1, clr1;
    logic       a_ready1, b1, busy1, ovf1;
    logic [3:0] dc1;

    int    tests = 0;
    int    fails = 0;
    string phase = "reset";

    typedef struct {
        logic       b;
        logic       busy;
        logic       rdy;
        logic       ovf;
        logic [7:0] dc;
    } exp_t;

    exp_t exp_q[$];
    logic a1_q[$];

    always #5 clk = ~clk;

    token_multiplier #(.FACTOR(2), .MAX_PENDING(4), .DROP_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .a_ready  (a_ready),
        .clr_ovf  (clr_ovf),
        .b        (b),
        .busy     (busy),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    token_multiplier #(.FACTOR(1), .MAX_PENDING(1), .DROP_W(4)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .a        (a1),
        .a_ready  (a_ready1),
        .clr_ovf  (clr1),
        .b        (b1),
        .busy     (busy1),
        .overflow (ovf1),
        .drop_cnt (dc1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected post-edge outputs, drive one edge, pop and compare.
    task automatic cyc(input logic av, input logic cv, input logic eb, input logic ebusy,
                       input logic erdy, input logic eovf, input logic [7:0] edc);
        exp_t e;
        e.b = eb; e.busy = ebusy; e.rdy = erdy; e.ovf = eovf; e.dc = edc;
        exp_q.push_back(e);
        a       = av;
        clr_ovf = cv;
        tick();
        e = exp_q.pop_front();
        chk("b",        b,        e.b);
        chk("busy",     busy,     e.busy);
        chk("a_ready",  a_ready,  e.rdy);
        chk("overflow", overflow, e.ovf);
        chk("drop_cnt", drop_cnt, e.dc);
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; clr_ovf = 1'b0; a1 = 1'b0; clr1 = 1'b0;
        tick();
        tick();
        chk("b",        b,        0);
        chk("busy",     busy,     0);
        chk("a_ready",  a_ready,  1);
        chk("overflow", overflow, 0);
        chk("drop_cnt", drop_cnt, 0);
        chk("b1",       b1,       0);
        chk("a_ready1", a_ready1, 1);
        rst = 1'b0;

        // Single token: b high in cycles 2 and 3.
        phase = "single";
        cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);

        // Alternating tokens: four back-to-back outputs.
        phase = "alt";
        cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);

        // Continuous input: backlog hits 4, drops every second edge, then clear interactions.
        phase = "hold";
        cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 1, 1);
        cyc(1, 0, 1, 1, 0, 1, 1);
        cyc(1, 0, 1, 1, 1, 1, 2);
        cyc(1, 0, 1, 1, 0, 1, 2);
        cyc(1, 0, 1, 1, 1, 1, 3);
        cyc(1, 0, 1, 1, 0, 1, 3);
        phase = "clr_drop";
        cyc(1, 1, 1, 1, 1, 1, 1);
        phase = "clr_only";
        cyc(0, 1, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);

        // Long overload: drop counter saturates.
        phase = "saturate";
        a = 1'b1;
        for (int i = 0; i < 600; i++) tick();
        chk("drop_cnt", drop_cnt, 8'hff);
        chk("overflow", overflow, 1);
        chk("b",        b,        1);
        chk("busy",     busy,     1);
        chk("a_ready",  a_ready,  1);

        // Reset with backlog 3 and b high: everything discarded.
        phase = "rst_mid";
        rst = 1'b1;
        tick();
        chk("b",        b,        0);
        chk("busy",     busy,     0);
        chk("overflow", overflow, 0);
        chk("drop_cnt", drop_cnt, 0);
        chk("a_ready",  a_ready,  1);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);

        // FACTOR=1: b is a delayed by exactly 2 cycles, never backpressured.
        phase = "factor1";
        for (int i = 0; i < 1000; i++) begin
            a1 = 1'($urandom_range(0, 1));
            a1_q.push_back(a1);
            tick();
            if (a1_q.size() >= 2) chk("b1", b1, a1_q.pop_front());
            chk("a_ready1", a_ready1, 1);
            chk("ovf1",     ovf1,     0);
        end
        chk("dc1", dc1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/token_multiplier.md
Name: token_multiplier

Overview:
- Serial block that multiplies incoming '1' tokens: each accepted token on `a` produces FACTOR '1' pulses on `b`.
- Output rate is at most one token per cycle.
- Surplus tokens are held in a pending backlog counter. The block applies backpressure through `a_ready` and records any dropped tokens.
- It is the expansion counterpart to the token-reduction blocks in the sequential-basics set, and sits on a single-bit token stream between serial stages.

Parameters:
- FACTOR, 2, number of output tokens generated per accepted input token; must be >= 1.
- MAX_PENDING, 4, capacity of the backlog counter; must be >= FACTOR.
- DROP_W, 8, width of the saturating dropped-token counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  1  incoming token; a '1' sampled at a clock edge is one token.
- a_ready  output  1  combinational from state only; high when a token on `a` will be accepted this edge.
- clr_ovf  input  1  clears `overflow` and `drop_cnt`.
- b  output  1  registered output token stream.
- busy  output  1  high when pending != 0 or b == 1.
- overflow  output  1  sticky flag; set when a token is dropped.
- drop_cnt  output  DROP_W  saturating count of dropped tokens.

Behaviour:
- State:
  - pending: unsigned, width $clog2(MAX_PENDING+1).
  - b register, overflow register, drop_cnt register.
- Reset (synchronous, rst=1 at an edge): pending=0, b=0, overflow=0, drop_cnt=0. Reset overrides all other inputs that edge, including a mid-burst backlog, which is discarded.
- Per edge, when not in reset:
  - emit = (pending != 0).
  - accept = a && a_ready.
  - drop = a && !a_ready.
  - b <= emit.
  - pending <= pending - emit + (accept ? FACTOR : 0). The computation uses a width at least one bit wider than pending; the result never exceeds MAX_PENDING.
- a_ready = (pending <= MAX_PENDING - FACTOR + 1). This guarantees the next pending value is <= MAX_PENDING, and the emit and accept in the same edge are both counted.
- Latency:
  - A token sampled at edge 0 makes b=1 during cycles 2 .. FACTOR+1, provided there is no other backlog.
  - Minimum input-to-output latency is 2 cycles.
  - Output tokens are emitted back-to-back, one per cycle, until the backlog drains.
- Token conservation: total b ones = FACTOR × accepted tokens, counted once the backlog has drained. No token is emitted for a dropped input.
- Overflow and drop counting:
  - On drop, overflow <= 1 and drop_cnt increments, saturating at all-ones.
  - clr_ovf=1 clears both. If clr_ovf and drop occur in the same edge, overflow <= 1 and drop_cnt <= 1 (set wins).
- FACTOR=1: a_ready is always high (pending never exceeds 1), so b equals a delayed by 2 cycles and overflow never sets.
- busy = (pending != 0) || b.
- Elaboration-time checks: FACTOR >= 1 and MAX_PENDING >= FACTOR, else fatal.

Decomposition:
- Shared package token_pkg holds:
  - the function that computes counter width from MAX_PENDING;
  - default constants TOKEN_FACTOR_DEF=2 and TOKEN_MAX_PENDING_DEF=4.
- Other token-stream blocks share these defaults.
- One natural sub-module: token_backlog_cnt, an up-by-FACTOR / down-by-1 bounded counter with a ready output. It is reusable by future token-rate blocks.
- The overflow flag and drop_cnt live in the top module.

Test Plan:
- FACTOR=2, MAX_PENDING=4; a=1 at edge 0 only -> b=1 in cycles 2,3, b=0 otherwise; busy high cycles 1–3; overflow stays 0.
- Sequence a=1,0,1,0 at edges 0–3 -> pending 2,1,2,1,0; b=1 in cycles 2–5 (four tokens); a_ready always 1.
- a held 1 from edge 0 -> pending 2,3,4,3,4,…; a_ready=0 whenever pending=4; first drop at edge 3; overflow=1 from cycle 4; drop_cnt increments every second edge thereafter.
- Continuous a during an active drop edge with clr_ovf=1 -> overflow stays 1 and drop_cnt=1 next cycle; clr_ovf with no drop -> overflow=0, drop_cnt=0.
- rst asserted at an edge where pending=3 and b=1 -> next cycle pending=0, b=0, busy=0, overflow=0; no residual output tokens.
- FACTOR=1 instance, random a for 1000 cycles -> b equals a delayed 2 cycles exactly; overflow=0; a_ready constantly 1.
